// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with valid/ready handshake and a single-entry output register.
// Round-robin arbitration is compiled in only when PRIO_ENC_RR_EN is defined; otherwise fixed priority.
module prio_encoder_rr #(
   parameter  int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         rr_mode,
   output logic [W-1:0] D,
   output logic         val,
   output logic         out_valid,
   input  logic         out_ready
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] d_q, d_d;
   logic         val_q, val_d;
   logic [W-1:0] fix_idx;
   logic [W-1:0] win_idx;
   logic         use_rr;
   logic         accept_in;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept_in = in_valid && in_ready;

   // Highest set index wins; later iterations override earlier ones.
   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) fix_idx = W'(i);
      end
   end

`ifdef PRIO_ENC_RR_EN
   logic [W-1:0] last_q, last_d;
   logic [W-1:0] rr_idx;

   // Rank each request by its descending distance from last, in 1..N (last itself ranks N).
   always_comb begin
      int best_rank;
      int rank;
      rr_idx    = '0;
      best_rank = N + 1;
      rank      = 0;
      for (int i = 0; i < N; i++) begin
         rank = int'(last_q) - i;
         if (rank <= 0) rank = rank + N;
         if (req[i] && (rank < best_rank)) begin
            best_rank = rank;
            rr_idx    = W'(i);
         end
      end
   end

   assign use_rr  = rr_mode;
   assign win_idx = use_rr ? rr_idx : fix_idx;

   always_comb begin
      last_d = last_q;
      if (accept_in && use_rr && (|req)) last_d = rr_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) last_q <= '0;
      else     last_q <= last_d;
   end
`else
   logic unused_rr_mode;
   assign unused_rr_mode = rr_mode;
   assign use_rr         = 1'b0;
   assign win_idx        = fix_idx;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      d_d         = d_q;
      val_d       = val_q;
      if (accept_in) begin
         out_valid_d = 1'b1;
         d_d         = win_idx;
         val_d       = |req;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         d_q         <= '0;
         val_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         d_q         <= d_d;
         val_q       <= val_d;
      end
   end

   assign out_valid = out_valid_q;
   assign D         = d_q;
   assign val       = val_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed and random checks of prio_encoder_rr (N=8) against a scan-order reference model.
module tb_prio_encoder_rr;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         in_valid;
   logic         in_ready;
   logic         rr_mode;
   logic [2:0]   D;
   logic         val;
   logic         out_valid;
   logic         out_ready;

   int n_err = 0;
   int n_chk = 0;

   // Reference state
   logic exp_ov = 1'b0;
   int   exp_d   = 0;
   logic exp_val = 1'b0;
   int   m_last  = 0;

   prio_encoder_rr #(.N(N)) dut (
      .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_ready(in_ready),
      .rr_mode(rr_mode), .D(D), .val(val), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Walk the requests in the order the rules define and return the first set one.
   function automatic int model_win(input logic [7:0] r, input logic rr, input int last);
      int idx;
      if (r == 8'h00) return 0;
      if (!rr) begin
         for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) begin
            idx = (last - k + N) % N;
            if (r[idx]) return idx;
         end
      end
      return 0;
   endfunction

   task automatic step(input logic r, input logic iv, input logic [7:0] rq,
                       input logic rm, input logic orr);
      logic rr_eff;
      logic acc;
      @(negedge clk);
      rst = r; in_valid = iv; req = rq; rr_mode = rm; out_ready = orr;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_ov || orr)});
`ifdef PRIO_ENC_RR_EN
      rr_eff = rm;
`else
      rr_eff = 1'b0;
`endif
      @(posedge clk);
      if (r) begin
         exp_ov = 1'b0; exp_d = 0; exp_val = 1'b0; m_last = 0;
      end else begin
         acc = iv && (!exp_ov || orr);
         if (acc) begin
            exp_ov  = 1'b1;
            exp_d   = model_win(rq, rr_eff, m_last);
            exp_val = (rq != 8'h00);
            if (rr_eff && exp_val) m_last = exp_d;
         end else if (orr) begin
            exp_ov = 1'b0;
         end
      end
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      if (exp_ov || r) begin
         chk("D", {29'd0, D}, exp_d);
         chk("val", {31'd0, val}, {31'd0, exp_val});
      end
      $display("txn rst=%0b iv=%0b req=%02h rr=%0b ordy=%0b -> ov=%0b D=%0d val=%0b", r, iv, rq, rm, orr, out_valid, D, val);
   endtask

   int sweep_exp [9];
   int gap_exp [3];

   initial begin
`ifdef PRIO_ENC_RR_EN
      sweep_exp = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
      gap_exp   = '{7, 0, 7};
`else
      sweep_exp = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
      gap_exp   = '{7, 7, 7};
`endif
      rst = 1'b1; in_valid = 1'b0; req = '0; rr_mode = 1'b0; out_ready = 1'b1;

      // Reset held with a live request
      step(1, 1, 8'hFF, 0, 1);
      step(1, 1, 8'hFF, 0, 1);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Fixed priority
      step(0, 1, 8'b0010_0110, 0, 1);
      chk("fixed_D", {29'd0, D}, 32'd5);
      step(0, 1, 8'h00, 0, 1);
      chk("zero_val", {31'd0, val}, 32'd0);
      chk("zero_ov", {31'd0, out_valid}, 32'd1);

      // Round-robin sweep
      step(1, 0, 8'h00, 0, 1);
      for (int i = 0; i < 9; i++) begin
         step(0, 1, 8'hFF, 1, 1);
         chk("sweep_D", {29'd0, D}, sweep_exp[i]);
      end

      // Round-robin with gaps
      step(1, 0, 8'h00, 0, 1);
      step(0, 1, 8'b1000_0001, 1, 1);
      chk("gap_D0", {29'd0, D}, gap_exp[0]);
      step(0, 1, 8'b1000_0001, 1, 1);
      chk("gap_D1", {29'd0, D}, gap_exp[1]);
      step(0, 1, 8'h00, 1, 1);
      chk("gap_val", {31'd0, val}, 32'd0);
      step(0, 1, 8'b1000_0001, 1, 1);
      chk("gap_D2", {29'd0, D}, gap_exp[2]);

      // Backpressure
      step(1, 0, 8'h00, 0, 1);
      step(0, 1, 8'h08, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 8'h80, 0, 0);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_D", {29'd0, D}, 32'd3);
      end
      step(0, 1, 8'h80, 0, 1);
      chk("release_D", {29'd0, D}, 32'd7);
      step(0, 0, 8'h00, 0, 1);
      chk("drain_ov", {31'd0, out_valid}, 32'd0);

      // Reset mid-operation in round-robin mode
      step(0, 1, 8'hFF, 1, 1);
      step(0, 1, 8'hFF, 1, 0);
      step(1, 1, 8'hFF, 1, 0);
      chk("midrst_ov", {31'd0, out_valid}, 32'd0);
      step(0, 1, 8'hFF, 1, 1);
      chk("midrst_D", {29'd0, D}, 32'd7);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
